calc_resp_engine: RTL and testbench

- Responder end of the four-port calculator request protocol driven by the team's calculator bench.
- Accepts command/operand pairs on four independent request ports and shares a single 32-bit ALU across them through an arbiter.
- Returns one response code and result word per request on the matching output port.
- Drop-in target for the existing four-channel bench stimulus (add, subtract, shift left, shift right, overflow/underflow, invalid command).

---
 rtl/calc_resp_engine_if.sv | 44 ++++
 rtl/calc_resp_engine.sv | 183 ++++++++++++++++++
 tb/tb_calc_resp_engine.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_resp_engine_if.sv
// Request/response bundle for the four-port calculator responder.
// master drives requests; slave (the engine) returns responses.
interface calc_resp_engine_if #(
  parameter int DATA_W = 32
);
  logic [3:0]        req1_cmd_in;
  logic [3:0]        req2_cmd_in;
  logic [3:0]        req3_cmd_in;
  logic [3:0]        req4_cmd_in;
  logic [DATA_W-1:0] req1_data_in;
  logic [DATA_W-1:0] req2_data_in;
  logic [DATA_W-1:0] req3_data_in;
  logic [DATA_W-1:0] req4_data_in;
  logic [1:0]        out_resp1;
  logic [1:0]        out_resp2;
  logic [1:0]        out_resp3;
  logic [1:0]        out_resp4;
  logic [DATA_W-1:0] out_data1;
  logic [DATA_W-1:0] out_data2;
  logic [DATA_W-1:0] out_data3;
  logic [DATA_W-1:0] out_data4;

  modport master (
    output req1_cmd_in, req2_cmd_in,
    output req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in,
    output req3_data_in, req4_data_in,
    input  out_resp1, out_resp2,
    input  out_resp3, out_resp4,
    input  out_data1, out_data2,
    input  out_data3, out_data4
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in,
    input  req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in,
    input  req3_data_in, req4_data_in,
    output out_resp1, out_resp2,
    output out_resp3, out_resp4,
    output out_data1, out_data2,
    output out_data3, out_data4
  );
endinterface

// File: rtl/calc_resp_engine.sv
// Four-port calculator responder sharing one ALU via an arbiter.
// CALC_FIXED_PRIORITY_EN: fixed priority (port 1 first), else round-robin.
module calc_resp_engine #(
  parameter int DATA_W    = 32,
  parameter int NUM_PORTS = 4,
  parameter int SHAMT_W   = 5
) (
  input logic              c_clk,
  input logic              reset,
  calc_resp_engine_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    OP2,
    QUEUED
  } st_e;

  st_e               st     [NUM_PORTS];
  logic [3:0]        cmd_in [NUM_PORTS];
  logic [DATA_W-1:0] din    [NUM_PORTS];
  logic [3:0]        cmd_q  [NUM_PORTS];
  logic [DATA_W-1:0] op1_q  [NUM_PORTS];
  logic [DATA_W-1:0] op2_q  [NUM_PORTS];
  logic [1:0]        resp_q [NUM_PORTS];
  logic [DATA_W-1:0] dout_q [NUM_PORTS];

  assign cmd_in[0] = bus.req1_cmd_in;
  assign cmd_in[1] = bus.req2_cmd_in;
  assign cmd_in[2] = bus.req3_cmd_in;
  assign cmd_in[3] = bus.req4_cmd_in;
  assign din[0]    = bus.req1_data_in;
  assign din[1]    = bus.req2_data_in;
  assign din[2]    = bus.req3_data_in;
  assign din[3]    = bus.req4_data_in;

  assign bus.out_resp1 = resp_q[0];
  assign bus.out_resp2 = resp_q[1];
  assign bus.out_resp3 = resp_q[2];
  assign bus.out_resp4 = resp_q[3];
  assign bus.out_data1 = dout_q[0];
  assign bus.out_data2 = dout_q[1];
  assign bus.out_data3 = dout_q[2];
  assign bus.out_data4 = dout_q[3];

  logic       gnt_vld;
  logic [1:0] gnt_idx;

`ifdef CALC_FIXED_PRIORITY_EN
  // Lowest-numbered queued port wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (st[k] == QUEUED) begin
        gnt_vld = 1'b1;
        gnt_idx = 2'(k);
      end
    end
  end
`else
  logic [1:0] ptr;
  logic [1:0] cand;

  // Round-robin: search from the port after the last grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 2'd0;
    cand    = 2'd0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = ptr + 2'(k + 1);
      if (!gnt_vld && st[cand] == QUEUED) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end
`endif

  logic [3:0]         a_cmd;
  logic [DATA_W-1:0]  a_op1;
  logic [DATA_W-1:0]  a_op2;
  logic [DATA_W:0]    a_sum;
  logic [SHAMT_W-1:0] a_sh;
  logic               is_add;
  logic               is_sub;
  logic               is_shl;
  logic               is_shr;
  logic [1:0]         alu_resp;
  logic [DATA_W-1:0]  alu_data;

  assign a_cmd  = cmd_q[gnt_idx];
  assign a_op1  = op1_q[gnt_idx];
  assign a_op2  = op2_q[gnt_idx];
  assign a_sum  = {1'b0, a_op1} + {1'b0, a_op2};
  assign a_sh   = a_op2[SHAMT_W-1:0];
  assign is_add = (a_cmd == 4'd1);
  assign is_sub = (a_cmd == 4'd2);
  assign is_shl = (a_cmd == 4'd5);
  assign is_shr = (a_cmd == 4'd6);

  // Shared stateless ALU on the granted port's operands.
  always_comb begin
    alu_resp = 2'd3;
    alu_data = '0;
    unique case (1'b1)
      is_add: begin
        if (a_sum[DATA_W]) begin
          alu_resp = 2'd2;
        end else begin
          alu_resp = 2'd1;
          alu_data = a_sum[DATA_W-1:0];
        end
      end
      is_sub: begin
        if (a_op1 < a_op2) begin
          alu_resp = 2'd2;
        end else begin
          alu_resp = 2'd1;
          alu_data = a_op1 - a_op2;
        end
      end
      is_shl: begin
        alu_resp = 2'd1;
        alu_data = a_op1 << a_sh;
      end
      is_shr: begin
        alu_resp = 2'd1;
        alu_data = a_op1 >> a_sh;
      end
      default: ;
    endcase
  end

  // Per-port FSMs with one-cycle registered responses.
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        st[p]     <= IDLE;
        cmd_q[p]  <= 4'd0;
        op1_q[p]  <= '0;
        op2_q[p]  <= '0;
        resp_q[p] <= 2'd0;
        dout_q[p] <= '0;
      end
`ifndef CALC_FIXED_PRIORITY_EN
      ptr <= 2'd3;
`endif
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        resp_q[p] <= 2'd0;
        dout_q[p] <= '0;
        unique case (st[p])
          IDLE: begin
            if (cmd_in[p] != 4'd0) begin
              cmd_q[p] <= cmd_in[p];
              op1_q[p] <= din[p];
              st[p]    <= OP2;
            end
          end
          OP2: begin
            op2_q[p] <= din[p];
            st[p]    <= QUEUED;
          end
          QUEUED: begin
            if (gnt_vld && gnt_idx == 2'(p)) begin
              resp_q[p] <= alu_resp;
              dout_q[p] <= alu_data;
              st[p]     <= IDLE;
            end
          end
          default: st[p] <= IDLE;
        endcase
      end
`ifndef CALC_FIXED_PRIORITY_EN
      if (gnt_vld) begin
        ptr <= gnt_idx;
      end
`endif
    end
  end

endmodule

// File: tb/tb_calc_resp_engine.sv
// Randomized and directed checks for calc_resp_engine.
// Expected results come from a plain-arithmetic model.
module tb_calc_resp_engine;

  logic        c_clk;
  logic        reset;
  logic [3:0]  cmd [4];
  logic [31:0] dat [4];
  logic [1:0]  ro  [4];
  logic [31:0] dq  [4];
  int          vec;
  int          err;

  calc_resp_engine_if bus ();

  assign bus.req1_cmd_in  = cmd[0];
  assign bus.req2_cmd_in  = cmd[1];
  assign bus.req3_cmd_in  = cmd[2];
  assign bus.req4_cmd_in  = cmd[3];
  assign bus.req1_data_in = dat[0];
  assign bus.req2_data_in = dat[1];
  assign bus.req3_data_in = dat[2];
  assign bus.req4_data_in = dat[3];
  assign ro[0] = bus.out_resp1;
  assign ro[1] = bus.out_resp2;
  assign ro[2] = bus.out_resp3;
  assign ro[3] = bus.out_resp4;
  assign dq[0] = bus.out_data1;
  assign dq[1] = bus.out_data2;
  assign dq[2] = bus.out_data3;
  assign dq[3] = bus.out_data4;

  calc_resp_engine dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  function automatic void model(
    input  logic [3:0]  c,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [1:0]  r,
    output logic [31:0] d
  );
    longint unsigned sa, sb, pw, lim;
    sa  = a;
    sb  = b;
    lim = 64'h1_0000_0000;
    pw  = 1;
    for (int i = 0; i < int'(b % 32); i++) pw = pw * 2;
    r = 2'd3;
    d = 32'd0;
    case (c)
      4'd1: begin
        if (sa + sb >= lim) r = 2'd2;
        else begin r = 2'd1; d = 32'(sa + sb); end
      end
      4'd2: begin
        if (sa < sb) r = 2'd2;
        else begin r = 2'd1; d = 32'(sa - sb); end
      end
      4'd5: begin r = 2'd1; d = 32'((sa * pw) % lim); end
      4'd6: begin r = 2'd1; d = 32'(sa / pw); end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  // Presents command+operand1, then operand2; returns after the operand2 edge.
  task automatic send(input int p, input logic [3:0] c,
                      input logic [31:0] a, input logic [31:0] b);
    cmd[p] = c;
    dat[p] = a;
    tick();
    cmd[p] = 4'd0;
    dat[p] = b;
    tick();
    dat[p] = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0;
      dat[p] = 32'd0;
    end
    repeat (3) tick();
    for (int p = 0; p < 4; p++) begin
      vec++;
      if (ro[p] !== 2'd0 || dq[p] !== 32'd0) begin
        err++;
        $display("FAIL reset_out p%0d got %0d/%h want 0/0", p + 1, ro[p], dq[p]);
      end
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_add();
    send(0, 4'd1, 32'h64, 32'h27);
    vec++;
    if (ro[0] !== 2'd0) begin
      err++;
      $display("FAIL add_early got %0d want 0", ro[0]);
    end
    tick();
    vec++;
    if (ro[0] !== 2'd1 || dq[0] !== 32'h8B) begin
      err++;
      $display("FAIL add_result got %0d/%h want 1/8b", ro[0], dq[0]);
    end
    for (int p = 1; p < 4; p++) begin
      vec++;
      if (ro[p] !== 2'd0 || dq[p] !== 32'd0) begin
        err++;
        $display("FAIL add_other p%0d got %0d/%h want 0/0", p + 1, ro[p], dq[p]);
      end
    end
    tick();
    vec++;
    if (ro[0] !== 2'd0 || dq[0] !== 32'd0) begin
      err++;
      $display("FAIL add_hold got %0d/%h want 0/0", ro[0], dq[0]);
    end
  endtask

  task automatic test_ovf_sub();
    int          tp [3] = '{1, 2, 2};
    logic [3:0]  tc [3] = '{4'd1, 4'd2, 4'd2};
    logic [31:0] ta [3] = '{32'hFFFF_FFFF, 32'h22, 32'h5};
    logic [31:0] tb [3] = '{32'h1, 32'h23, 32'h2};
    logic [1:0]  er [3] = '{2'd2, 2'd2, 2'd1};
    logic [31:0] ed [3] = '{32'h0, 32'h0, 32'h3};
    for (int i = 0; i < 3; i++) begin
      send(tp[i], tc[i], ta[i], tb[i]);
      tick();
      vec++;
      if (ro[tp[i]] !== er[i] || dq[tp[i]] !== ed[i]) begin
        err++;
        $display("FAIL ovf_sub%0d got %0d/%h want %0d/%h",
                 i, ro[tp[i]], dq[tp[i]], er[i], ed[i]);
      end
      tick();
    end
  endtask

  task automatic test_shift();
    logic [3:0]  tc [3] = '{4'd5, 4'd6, 4'd5};
    logic [31:0] ta [3] = '{32'h3, 32'hC, 32'h3};
    logic [31:0] tb [3] = '{32'h2, 32'h2, 32'h21};
    logic [31:0] ed [3] = '{32'hC, 32'h3, 32'h6};
    for (int i = 0; i < 3; i++) begin
      send(3, tc[i], ta[i], tb[i]);
      tick();
      vec++;
      if (ro[3] !== 2'd1 || dq[3] !== ed[i]) begin
        err++;
        $display("FAIL shift%0d got %0d/%h want 1/%h", i, ro[3], dq[3], ed[i]);
      end
      tick();
    end
  endtask

  task automatic test_arb();
    int order [4];
`ifdef CALC_FIXED_PRIORITY_EN
    order = '{0, 1, 2, 3};
`else
    order = '{1, 2, 3, 0};
`endif
    send(0, 4'd1, 32'd1, 32'd1);
    tick();
    vec++;
    if (ro[0] !== 2'd1 || dq[0] !== 32'd2) begin
      err++;
      $display("FAIL arb_burst1 got %0d/%h want 1/2", ro[0], dq[0]);
    end
    tick();
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd1;
      dat[p] = 32'd1;
    end
    tick();
    for (int p = 0; p < 4; p++) cmd[p] = 4'd0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      for (int p = 0; p < 4; p++) begin
        logic [1:0]  xr;
        logic [31:0] xd;
        xr = (p == order[i]) ? 2'd1 : 2'd0;
        xd = (p == order[i]) ? 32'd2 : 32'd0;
        vec++;
        if (ro[p] !== xr || dq[p] !== xd) begin
          err++;
          $display("FAIL arb_c%0d_p%0d got %0d/%h want %0d/%h",
                   i, p + 1, ro[p], dq[p], xr, xd);
        end
      end
    end
    tick();
  endtask

  task automatic test_invalid_drop();
    send(0, 4'd9, $urandom, $urandom);
    tick();
    vec++;
    if (ro[0] !== 2'd3 || dq[0] !== 32'd0) begin
      err++;
      $display("FAIL invalid got %0d/%h want 3/0", ro[0], dq[0]);
    end
    tick();
    send(0, 4'd1, 32'd10, 32'd20);
    cmd[0] = 4'd1;
    dat[0] = 32'd77;
    tick();
    cmd[0] = 4'd0;
    vec++;
    if (ro[0] !== 2'd1 || dq[0] !== 32'd30) begin
      err++;
      $display("FAIL drop_first got %0d/%h want 1/1e", ro[0], dq[0]);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      vec++;
      if (ro[0] !== 2'd0) begin
        err++;
        $display("FAIL drop_late c%0d got %0d want 0", i, ro[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    send(2, 4'd1, 32'd3, 32'd4);
    tick();
    vec++;
    if (ro[2] !== 2'd1 || dq[2] !== 32'd7) begin
      err++;
      $display("FAIL b2b_first got %0d/%h want 1/7", ro[2], dq[2]);
    end
    cmd[2] = 4'd2;
    dat[2] = 32'd9;
    tick();
    cmd[2] = 4'd0;
    dat[2] = 32'd4;
    tick();
    tick();
    vec++;
    if (ro[2] !== 2'd1 || dq[2] !== 32'd5) begin
      err++;
      $display("FAIL b2b_second got %0d/%h want 1/5", ro[2], dq[2]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    cmd[1] = 4'd1;
    dat[1] = $urandom;
    tick();
    cmd[1] = 4'd0;
    dat[1] = $urandom;
    reset  = 1'b0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      for (int p = 0; p < 4; p++) begin
        vec++;
        if (ro[p] !== 2'd0 || dq[p] !== 32'd0) begin
          err++;
          $display("FAIL rst_mid c%0d p%0d got %0d/%h want 0/0",
                   i, p + 1, ro[p], dq[p]);
        end
      end
      tick();
    end
    send(1, 4'd1, 32'd5, 32'd1);
    tick();
    vec++;
    if (ro[1] !== 2'd1 || dq[1] !== 32'd6) begin
      err++;
      $display("FAIL rst_after got %0d/%h want 1/6", ro[1], dq[1]);
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0]  ops [4] = '{4'd1, 4'd2, 4'd5, 4'd6};
    for (int n = 0; n < 60; n++) begin
      int          p;
      logic [3:0]  c;
      logic [31:0] a, b, xd;
      logic [1:0]  xr;
      p = $urandom_range(0, 3);
      if ($urandom_range(0, 4) != 0) c = ops[$urandom_range(0, 3)];
      else c = 4'($urandom_range(1, 15));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 1) != 0) b = a + 32'($urandom_range(0, 4)) - 32'd2;
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      model(c, a, b, xr, xd);
      send(p, c, a, b);
      vec++;
      if (ro[p] !== 2'd0) begin
        err++;
        $display("FAIL rnd_early n%0d got %0d want 0", n, ro[p]);
      end
      tick();
      for (int q = 0; q < 4; q++) begin
        logic [1:0]  wr;
        logic [31:0] wd;
        wr = (q == p) ? xr : 2'd0;
        wd = (q == p) ? xd : 32'd0;
        vec++;
        if (ro[q] !== wr || dq[q] !== wd) begin
          err++;
          $display("FAIL rnd n%0d p%0d cmd%0d a=%h b=%h got %0d/%h want %0d/%h",
                   n, q + 1, c, a, b, ro[q], dq[q], wr, wd);
        end
      end
      tick();
      vec++;
      if (ro[p] !== 2'd0) begin
        err++;
        $display("FAIL rnd_hold n%0d got %0d want 0", n, ro[p]);
      end
    end
  endtask

  initial begin
    vec = 0;
    err = 0;
    test_reset();
    test_add();
    test_ovf_sub();
    test_shift();
    test_arb();
    test_invalid_drop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
